// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter and its downstream grant controller.
package arb_pkg;

    localparam int NUM_MASTERS = 3;

    // Bus source index reported when no master owns the shared bus.
    localparam logic [1:0] SRC_NONE = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        DONE,
        ABORT,
        RELEASE
    } bgc_state_t;

    // One-hot per-master vector for a master index; an out-of-range index gives all zeros.
    function automatic logic [NUM_MASTERS-1:0] src_onehot(input logic [1:0] src);
        logic [NUM_MASTERS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (src == 2'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/bus_grant_controller_beat_counter.sv
// Counts accepted beats of the current burst and flags when the next beat is the last one.
module beat_counter
    import arb_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             beat,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] beat_cnt,
    output logic             last
);

    // Beat count restarts on each new grant and advances on every accepted beat.
    // len is at most 2**LEN_W-1, so the count can reach len without wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    // A zero-length burst never reaches the transfer phase, so it never has a last beat.
    always_comb begin
        last = (len != '0) && (beat_cnt == (len - LEN_W'(1)));
    end

endmodule

// File: rtl/bus_grant_controller.sv
// Latches the arbiter-granted master and its burst length, muxes its beats onto
// the shared bus, bounds bus tenure with a hold timer and reports done/abort.
module bus_grant_controller
    import arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 8,
    parameter int MAX_HOLD = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          g0,
    input  logic                          g1,
    input  logic                          g2,
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_data,
    input  logic [NUM_MASTERS*LEN_W-1:0]  m_len,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic                          bus_valid,
    output logic [DATA_W-1:0]             bus_data,
    output logic [1:0]                    bus_src,
    input  logic                          bus_ready,
    output logic [NUM_MASTERS-1:0]        done,
    output logic [NUM_MASTERS-1:0]        abort,
    output logic                          busy,
    output logic                          grant_err
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    bgc_state_t state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   grant_err_d;
    logic [NUM_MASTERS-1:0] done_d, abort_d;
    logic [1:0]             bus_src_d;

    logic [NUM_MASTERS-1:0] g_vec;
    logic [1:0]             grant_sum;
    logic [1:0]             grant_idx;
    logic [LEN_W-1:0]       grant_len;
    logic                   owner_granted;
    logic                   beat;
    logic                   cnt_clear;
    logic                   last_beat;
    logic [LEN_W-1:0]       beat_cnt;

    assign g_vec = {g2, g1, g0};

    // Decode the incoming grants: how many are high, and which master/length a single grant selects.
    always_comb begin
        grant_sum = {1'b0, g0} + {1'b0, g1} + {1'b0, g2};
        grant_idx = 2'd0;
        grant_len = m_len[LEN_W-1:0];
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (g_vec[i]) begin
                grant_idx = 2'(i);
                grant_len = m_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Owner-side mux: only during XFER does the owner see the bus; a dropped grant blocks acceptance.
    always_comb begin
        owner_granted = 1'b0;
        bus_valid     = 1'b0;
        bus_data      = '0;
        m_ready       = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == 2'(i)) begin
                owner_granted = g_vec[i];
                if (state_q == XFER) begin
                    bus_valid  = m_valid[i];
                    bus_data   = m_data[i*DATA_W +: DATA_W];
                    m_ready[i] = bus_ready & g_vec[i];
                end
            end
        end
        beat = (state_q == XFER) & bus_valid & bus_ready & owner_granted;
    end

    beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .beat     (beat),
        .len      (len_q),
        .beat_cnt (beat_cnt),
        .last     (last_beat)
    );

    // Next-state logic; grant loss outranks burst completion, which outranks the hold timeout.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        len_d       = len_q;
        hold_d      = hold_q;
        grant_err_d = grant_err;
        cnt_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_sum == 2'd1) begin
                    owner_d   = grant_idx;
                    len_d     = grant_len;
                    hold_d    = '0;
                    cnt_clear = 1'b1;
                    state_d   = (grant_len != '0) ? XFER : DONE;
                end else if (grant_sum > 2'd1) begin
                    grant_err_d = 1'b1;
                end
            end
            XFER: begin
                if (hold_q != {HOLD_W{1'b1}}) hold_d = hold_q + HOLD_W'(1);
                if (!owner_granted) begin
                    state_d = ABORT;
                end else if (beat && last_beat) begin
                    state_d = DONE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ABORT;
                end
            end
            DONE:    state_d = RELEASE;
            ABORT:   state_d = RELEASE;
            RELEASE: begin
                if (!owner_granted) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d    = (state_d == DONE)  ? src_onehot(owner_d) : '0;
        abort_d   = (state_d == ABORT) ? src_onehot(owner_d) : '0;
        bus_src_d = (state_d == XFER)  ? owner_d : SRC_NONE;
    end

    // State and registered outputs; reset returns to IDLE at once with no pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            len_q     <= '0;
            hold_q    <= '0;
            grant_err <= 1'b0;
            done      <= '0;
            abort     <= '0;
            bus_src   <= SRC_NONE;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            len_q     <= len_d;
            hold_q    <= hold_d;
            grant_err <= grant_err_d;
            done      <= done_d;
            abort     <= abort_d;
            bus_src   <= bus_src_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_bus_grant_controller.sv
// Bench for bus_grant_controller: directed scenarios plus randomized bursts
// checked against a burst-level outcome predictor.
module tb_bus_grant_controller;

    localparam int DATA_W   = 32;
    localparam int LEN_W    = 8;
    localparam int MAX_HOLD = 8;
    localparam int NM       = 3;

    logic                   clk;
    logic                   reset;
    logic                   g0, g1, g2;
    logic [NM-1:0]          m_valid;
    logic [NM*DATA_W-1:0]   m_data;
    logic [NM*LEN_W-1:0]    m_len;
    logic [NM-1:0]          m_ready;
    logic                   bus_valid;
    logic [DATA_W-1:0]      bus_data;
    logic [1:0]             bus_src;
    logic                   bus_ready;
    logic [NM-1:0]          done;
    logic [NM-1:0]          abort;
    logic                   busy;
    logic                   grant_err;

    int checks = 0;
    int errors = 0;

    bus_grant_controller #(
        .DATA_W   (DATA_W),
        .LEN_W    (LEN_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .g0        (g0),
        .g1        (g1),
        .g2        (g2),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_len     (m_len),
        .m_ready   (m_ready),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_src   (bus_src),
        .bus_ready (bus_ready),
        .done      (done),
        .abort     (abort),
        .busy      (busy),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_g(input logic [2:0] v);
        {g2, g1, g0} = v;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_src"},   64'(bus_src), 64'd3);
        chk({tag, "_done"},  64'(done), 64'd0);
        chk({tag, "_abort"}, 64'(abort), 64'd0);
        chk({tag, "_err"},   64'(grant_err), 64'd0);
        chk({tag, "_bval"},  64'(bus_valid), 64'd0);
        chk({tag, "_bdat"},  64'(bus_data), 64'd0);
        chk({tag, "_mrdy"},  64'(m_ready), 64'd0);
    endtask

    // One burst from grant to return to idle.
    // vmode: -1 random valid, else fixed; rmode: 0 random, 1 always ready, 2 toggle 1,0,1...
    // d: XFER cycle index at which the grant drops (-1 = held until release).
    task automatic run_burst(input int i, input int L, input int vmode, input int rmode, input int d);
        bit          vv[MAX_HOLD];
        bit          rr[MAX_HOLD];
        int          nb;
        int          term;
        int          obs_beats;
        int          hold;
        bit          is_done;
        bit          dropped;
        logic [2:0]  gbit;
        logic [2:0]  exp_rdy;

        gbit = 3'(1 << i);
        for (int k = 0; k < MAX_HOLD; k++) begin
            vv[k] = (vmode < 0) ? 1'($urandom_range(0, 1)) : 1'(vmode);
            rr[k] = (rmode == 0) ? 1'($urandom_range(0, 1)) : (rmode == 1) ? 1'b1 : 1'((k % 2) == 0);
        end

        // Predict the burst outcome: number of beats, last XFER cycle, and done vs abort.
        nb = 0;
        term = -1;
        is_done = (L == 0);
        if (L != 0) begin
            for (int k = 0; k < MAX_HOLD && term < 0; k++) begin
                if (k == d) begin
                    term = k;
                end else begin
                    if (vv[k] && rr[k]) nb++;
                    if (nb == L) begin
                        term = k;
                        is_done = 1'b1;
                    end else if (k == MAX_HOLD - 1) begin
                        term = k;
                    end
                end
            end
        end
        dropped = (L != 0) && (d >= 0) && (d <= term);

        // Grant cycle: controller still idle.
        @(negedge clk);
        set_g(gbit);
        m_len = {NM*LEN_W{1'b0}} | {8'($urandom), 8'($urandom), 8'($urandom)};
        m_len[i*LEN_W +: LEN_W] = LEN_W'(L);
        m_valid = 3'($urandom);
        bus_ready = 1'($urandom);
        #1;
        chk("grant_busy", 64'(busy), 64'd0);
        chk("grant_src", 64'(bus_src), 64'd3);

        obs_beats = 0;
        if (L != 0) begin
            for (int k = 0; k <= term; k++) begin
                @(negedge clk);
                set_g((d >= 0 && k >= d) ? 3'b000 : gbit);
                m_valid = 3'($urandom);
                m_valid[i] = vv[k];
                bus_ready = rr[k];
                m_data = {$urandom, $urandom, $urandom};
                #1;
                exp_rdy = (k == d) ? 3'b000 : (rr[k] ? gbit : 3'b000);
                chk("xfer_busy",  64'(busy), 64'd1);
                chk("xfer_src",   64'(bus_src), 64'(i));
                chk("xfer_bval",  64'(bus_valid), 64'(vv[k]));
                chk("xfer_mrdy",  64'(m_ready), 64'(exp_rdy));
                chk("xfer_bdat",  64'(bus_data), 64'(m_data[i*DATA_W +: DATA_W]));
                chk("xfer_pulse", 64'({done, abort}), 64'd0);
                if (bus_valid && m_ready[i]) obs_beats++;
            end
        end
        chk("burst_beats", 64'(obs_beats), 64'(nb));

        // Completion pulse cycle.
        @(negedge clk);
        set_g(dropped ? 3'b000 : gbit);
        m_valid = 3'($urandom);
        bus_ready = 1'($urandom);
        #1;
        chk("pulse_done",  64'(done),  64'(is_done ? gbit : 3'b000));
        chk("pulse_abort", 64'(abort), 64'(is_done ? 3'b000 : gbit));
        chk("pulse_bval",  64'(bus_valid), 64'd0);
        chk("pulse_mrdy",  64'(m_ready), 64'd0);
        chk("pulse_src",   64'(bus_src), 64'd3);
        chk("pulse_busy",  64'(busy), 64'd1);

        // Release: held grant keeps the controller parked; a competing grant is ignored.
        hold = dropped ? 0 : $urandom_range(0, 2);
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            set_g(gbit | ((j == 0) ? 3'(1 << ((i + 1) % NM)) : 3'b000));
            #1;
            chk("rel_busy",  64'(busy), 64'd1);
            chk("rel_src",   64'(bus_src), 64'd3);
            chk("rel_bval",  64'(bus_valid), 64'd0);
            chk("rel_pulse", 64'({done, abort}), 64'd0);
        end
        @(negedge clk);
        set_g(3'b000);
        #1;
        chk("rel_last_busy", 64'(busy), 64'd1);
        chk("rel_last_mrdy", 64'(m_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("back_idle_busy", 64'(busy), 64'd0);
        chk("back_idle_src",  64'(bus_src), 64'd3);
    endtask

    initial begin
        reset = 1'b0;
        set_g(3'b000);
        m_valid = '0;
        m_data = '0;
        m_len = '0;
        bus_ready = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_reset_busy", 64'(busy), 64'd0);

        // Full burst, always valid and ready.
        run_burst(1, 4, 1, 1, -1);
        // Backpressure toggling.
        run_burst(0, 3, 1, 2, -1);
        // Hold timeout with a silent master.
        run_burst(2, 10, 0, 0, -1);
        // Grant dropped after two beats.
        run_burst(0, 5, 1, 1, 2);
        // Zero-length burst.
        run_burst(1, 0, 1, 1, -1);
        // Completing beat on the final hold cycle wins over timeout.
        run_burst(2, MAX_HOLD, 1, 1, -1);

        // Randomized bursts.
        for (int n = 0; n < 40; n++) begin
            run_burst($urandom_range(0, NM - 1), $urandom_range(0, 10), -1, 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_HOLD - 1) : -1);
        end

        // Multi-hot grant in IDLE: sticky error, no transfer.
        @(negedge clk);
        set_g(3'b011);
        m_valid = 3'b111;
        bus_ready = 1'b1;
        #1;
        chk("multi_err_before", 64'(grant_err), 64'd0);
        @(negedge clk);
        set_g(3'b000);
        #1;
        chk("multi_err",  64'(grant_err), 64'd1);
        chk("multi_busy", 64'(busy), 64'd0);
        chk("multi_bval", 64'(bus_valid), 64'd0);
        chk("multi_src",  64'(bus_src), 64'd3);
        chk("multi_mrdy", 64'(m_ready), 64'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("multi_sticky", 64'(grant_err), 64'd1);
            chk("multi_idle",   64'(busy), 64'd0);
        end
        run_burst(2, 2, 1, 1, -1);
        chk("multi_sticky_after", 64'(grant_err), 64'd1);

        // Asynchronous reset in the middle of a transfer.
        @(negedge clk);
        set_g(3'b001);
        m_len[LEN_W-1:0] = LEN_W'(5);
        m_valid = 3'b001;
        bus_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_xfer_busy", 64'(busy), 64'd1);
        chk("midrst_xfer_bval", 64'(bus_valid), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(negedge clk);
        set_g(3'b000);
        reset = 1'b1;
        #1;
        chk("midrst_after_busy", 64'(busy), 64'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("midrst_no_pulse", 64'({done, abort}), 64'd0);
            chk("midrst_idle_src", 64'(bus_src), 64'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
